// File: rtl/calc_if.sv
// Request/response bundle between operand capture logic and calc_core.
// The master drives the request; the slave returns status and results.
interface calc_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [1:0]       fct_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] res_o;
  logic [WIDTH-1:0] rem_o;
  logic             err_o;

  modport master (
    output start_i, a_i, b_i, fct_i,
    input  busy_o, done_o, res_o, rem_o, err_o
  );

  modport slave (
    input  start_i, a_i, b_i, fct_i,
    output busy_o, done_o, res_o, rem_o, err_o
  );
endinterface

// File: rtl/calc_core.sv
// Multi-cycle unsigned arithmetic unit: add, sub, shift-add multiply and
// restoring divide, with registered results and a one-cycle done strobe.
module calc_core #(
  parameter int WIDTH = 8
) (
  input logic  clock_i,
  input logic  reset_i,
  calc_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [1:0] {FN_ADD, FN_SUB, FN_MUL, FN_DIV} fct_e;

  state_e           state_q;
  fct_e             fct_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  // hi/lo hold the product halves during mul and remainder/quotient during div.
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH:0]   add_sum, sub_dif, mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic             last_iter;

  always_comb begin
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    sub_dif   = {1'b0, a_q} - {1'b0, b_q};
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    // A set top bit means the trial subtraction underflowed: restore.
    if (div_diff[WIDTH]) begin
      div_hi = div_shift[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b0};
    end else begin
      div_hi = div_diff[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b1};
    end
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      fct_q      <= FN_ADD;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.res_o  <= '0;
      bus.rem_o  <= '0;
      bus.err_o  <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            a_q        <= bus.a_i;
            b_q        <= bus.b_i;
            fct_q      <= fct_e'(bus.fct_i);
            cnt_q      <= '0;
            hi_q       <= '0;
            // Multiplier shifts out of lo for mul; dividend shifts out for div.
            lo_q       <= bus.fct_i[0] ? bus.a_i : bus.b_i;
            bus.busy_o <= 1'b1;
            state_q    <= EXEC;
          end
        end

        EXEC: begin
          unique case (fct_q)
            FN_ADD: begin
              bus.res_o  <= add_sum[WIDTH-1:0];
              bus.rem_o  <= {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
              bus.err_o  <= 1'b0;
              bus.busy_o <= 1'b0;
              bus.done_o <= 1'b1;
              state_q    <= DONE;
            end
            FN_SUB: begin
              bus.res_o  <= sub_dif[WIDTH-1:0];
              bus.rem_o  <= {{(WIDTH-1){1'b0}}, sub_dif[WIDTH]};
              bus.err_o  <= 1'b0;
              bus.busy_o <= 1'b0;
              bus.done_o <= 1'b1;
              state_q    <= DONE;
            end
            FN_MUL: begin
              hi_q  <= mul_hi;
              lo_q  <= mul_lo;
              cnt_q <= cnt_q + 1'b1;
              if (last_iter) begin
                bus.res_o  <= mul_lo;
                bus.rem_o  <= mul_hi;
                bus.err_o  <= 1'b0;
                bus.busy_o <= 1'b0;
                bus.done_o <= 1'b1;
                state_q    <= DONE;
              end
            end
            FN_DIV: begin
              if (b_q == '0) begin
                bus.res_o  <= '1;
                bus.rem_o  <= a_q;
                bus.err_o  <= 1'b1;
                bus.busy_o <= 1'b0;
                bus.done_o <= 1'b1;
                state_q    <= DONE;
              end else begin
                hi_q  <= div_hi;
                lo_q  <= div_lo;
                cnt_q <= cnt_q + 1'b1;
                if (last_iter) begin
                  bus.res_o  <= div_lo;
                  bus.rem_o  <= div_hi;
                  bus.err_o  <= 1'b0;
                  bus.busy_o <= 1'b0;
                  bus.done_o <= 1'b1;
                  state_q    <= DONE;
                end
              end
            end
            default: state_q <= DONE;
          endcase
        end

        DONE: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
